// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
//   Shared types and constants for the sequential ALU:
//   - op_e    : command opcodes (any other 4-bit code is illegal)
//   - state_e : control FSM states
//   - ERR_*   : bit positions inside the 2-bit error flag vector
// -----------------------------------------------------------------------------
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_MUL = 4'b0100,
    OP_DIV = 4'b0101,
    OP_MOD = 4'b0110
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ITER,
    DONE
  } state_e;

  localparam int ERR_CARRY = 0;  // carry/borrow (unsigned) or overflow (signed)
  localparam int ERR_DIVZ  = 1;  // divide by zero

endpackage

// File: rtl/seq_alu_iter.sv
// -----------------------------------------------------------------------------
// seq_alu_iter
//   Iterative engine shared by MUL and DIV/MOD. One 2*WIDTH-bit shift register
//   holds either {partial product high, multiplier} (shift-add multiply, shifts
//   right) or {partial remainder, dividend/quotient} (restoring divide, shifts
//   left). Each busy cycle performs one step; WIDTH steps in total.
//
// Ports
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load opa/opb/div_mode and begin WIDTH iterations
//   div_mode   : 0 = multiply, 1 = divide
//   opa, opb   : multiplicand/multiplier or dividend/divisor (unsigned)
//   done       : all iterations complete, acc is final
//   acc        : MUL: full product; DIV: {remainder, quotient}
// -----------------------------------------------------------------------------
module seq_alu_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               div_mode,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               done,
  output logic [2*WIDTH-1:0] acc
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   opb_q;
  logic               div_mode_q;
  logic [2*WIDTH-1:0] acc_q;

  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               fits;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] step_next;

  // NOTE: every variable written in always_comb gets a value on entry, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    hi        = acc_q[2*WIDTH-1:WIDTH];
    lo        = acc_q[WIDTH-1:0];
    // Multiply step: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole register right by one.
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb_q} : '0);
    // Divide step: shift {rem, quo} left by one; the shifted remainder needs
    // one extra bit before the trial subtraction.
    rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
    fits      = (rem_sh >= {1'b0, opb_q});
    // When the divisor fits, the difference is below the divisor, so WIDTH
    // bits of the subtraction are exact.
    rem_new   = fits ? (rem_sh[WIDTH-1:0] - opb_q) : rem_sh[WIDTH-1:0];
    step_next = div_mode_q ? {rem_new, lo[WIDTH-2:0], fits}
                           : {mul_sum, lo[WIDTH-1:1]};
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      opb_q      <= '0;
      div_mode_q <= 1'b0;
      acc_q      <= '0;
    end else if (start) begin
      count_q    <= CNT_W'(WIDTH);
      opb_q      <= opb;
      div_mode_q <= div_mode;
      acc_q      <= {{WIDTH{1'b0}}, opa};
    end else if (count_q != '0) begin
      count_q    <= count_q - CNT_W'(1);
      acc_q      <= step_next;
    end
  end

  assign done = (count_q == '0);
  assign acc  = acc_q;

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Clocked ALU with valid/ready handshakes, one operation in flight.
//   ADD/SUB complete one cycle after accept; MUL/DIV/MOD run WIDTH iterations
//   in seq_alu_iter and complete WIDTH+1 cycles after accept. Divide by zero
//   and illegal opcodes complete one cycle after accept with OUT=0.
//
//   Optional feature macro: ALU_SIGNED_EN adds the sgn port; sgn=1 selects
//   two's complement operands and results. Without it all ops are unsigned.
//
// Ports
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : command handshake (in_ready high only in IDLE)
//   in1, in2             : operands (dividend/minuend, divisor/subtrahend)
//   op                   : opcode, see seq_alu_pkg::op_e
//   sgn                  : signed mode (ALU_SIGNED_EN only)
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   out                  : 2*WIDTH result, held stable while in DONE
//   err                  : [0] carry/borrow/overflow, [1] divide by zero
// -----------------------------------------------------------------------------
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [3:0]         op,
`ifdef ALU_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic [1:0]         err
);

  localparam int W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic             neg_q;      // final result must be negated (signed MUL/DIV/MOD)
  logic [W2-1:0]    out_q;
  logic [1:0]       err_q;

  logic             sgn_in;
  logic             accept;
  logic             op_iter;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             iter_done;
  logic [W2-1:0]    iter_acc;
  logic             load_result;

  logic [W2-1:0]    ext_a, ext_b, sum, diff;
  logic [W2-1:0]    prod_mag, quo_mag, rem_mag;
  logic [W2-1:0]    res_d;
  logic [1:0]       err_d;

`ifdef ALU_SIGNED_EN
  assign sgn_in = sgn;
`else
  assign sgn_in = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign err       = err_q;

  assign accept  = in_valid && in_ready;
  // Divide by zero never enters the iterative engine.
  assign op_iter = (op == OP_MUL) ||
                   (((op == OP_DIV) || (op == OP_MOD)) && (in2 != '0));

  // The engine works on magnitudes; signs are restored when the result is
  // registered, so signed mode costs no extra cycles.
  assign a_neg = sgn_in && in1[WIDTH-1];
  assign b_neg = sgn_in && in2[WIDTH-1];
  assign a_mag = a_neg ? -in1 : in1;
  assign b_mag = b_neg ? -in2 : in2;

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept && op_iter),
    .div_mode (op != OP_MUL),
    .opa      (a_mag),
    .opb      (b_mag),
    .done     (iter_done),
    .acc      (iter_acc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = op_iter ? ITER : EXEC;
      EXEC: state_d = DONE;
      ITER: if (iter_done) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign load_result = (state_q == EXEC) || ((state_q == ITER) && iter_done);

  always_comb begin
    res_d    = '0;
    err_d    = '0;
    ext_a    = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b    = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    sum      = ext_a + ext_b;
    diff     = ext_a - ext_b;
    prod_mag = iter_acc;
    quo_mag  = {{WIDTH{1'b0}}, iter_acc[WIDTH-1:0]};
    rem_mag  = {{WIDTH{1'b0}}, iter_acc[W2-1:WIDTH]};
    case (op_q)
      OP_ADD: begin
        res_d = sum;
        err_d[ERR_CARRY] = sgn_q ? ((a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                    (sum[WIDTH-1] != a_q[WIDTH-1]))
                                 : sum[WIDTH];
      end
      OP_SUB: begin
        res_d = diff;
        err_d[ERR_CARRY] = sgn_q ? ((a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                    (diff[WIDTH-1] != a_q[WIDTH-1]))
                                 : (a_q < b_q);
      end
      OP_MUL: res_d = neg_q ? -prod_mag : prod_mag;
      OP_DIV: begin
        if (b_q == '0) err_d[ERR_DIVZ] = 1'b1;
        else           res_d = neg_q ? -quo_mag : quo_mag;
      end
      OP_MOD: begin
        if (b_q == '0) err_d[ERR_DIVZ] = 1'b1;
        else           res_d = neg_q ? -rem_mag : rem_mag;
      end
      default: ;  // illegal opcode: OUT=0, ERR=00
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      out_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op;
        a_q   <= in1;
        b_q   <= in2;
        sgn_q <= sgn_in;
        // Remainder takes the dividend's sign; product/quotient the XOR.
        neg_q <= (op == OP_MOD) ? a_neg : (a_neg ^ b_neg);
      end
      // Result and flags change only on entry to DONE, so they hold under
      // backpressure and keep their last value outside DONE.
      if (load_result) begin
        out_q <= res_d;
        err_q <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//   Directed self-checking bench for seq_alu at WIDTH=16. Each scenario task
//   drives its stimulus and compares outputs against hand-computed values.
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.
//   Signed scenarios are built only when ALU_SIGNED_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int WIDTH = 16;
  localparam int LAT_LIMIT = 100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in1, in2;
  logic [3:0]        op;
`ifdef ALU_SIGNED_EN
  logic              sgn;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDTH-1:0] out;
  logic [1:0]        err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .op        (op),
`ifdef ALU_SIGNED_EN
    .sgn       (sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .err       (err)
  );

  // Issue one command from IDLE and wait (bounded) for the result.
  // lat counts rising edges after the accept edge until out_valid.
  task automatic run_op(input logic [3:0] o, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic s,
                        output logic [2*WIDTH-1:0] r, output logic [1:0] e,
                        output int lat);
    in1 = a; in2 = b; op = o;
`ifdef ALU_SIGNED_EN
    sgn = s;
`else
    if (s) $display("note: signed request ignored, ALU_SIGNED_EN not defined");
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs after accept; the captured command must not change.
    in1 = 16'hDEAD; in2 = 16'hBEEF; op = 4'b1111;
    lat = 0;
    while (out_valid !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    r = out; e = err;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [2*WIDTH-1:0] r,
                              input logic [1:0] e, input int lat,
                              input logic [2*WIDTH-1:0] exp_r,
                              input logic [1:0] exp_e, input int exp_lat);
    total++;
    if (r !== exp_r) $display("FAIL %s out: got %0h expected %0h", name, r, exp_r);
    else passed++;
    total++;
    if (e !== exp_e) $display("FAIL %s err: got %b expected %b", name, e, exp_e);
    else passed++;
    total++;
    if (lat !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in1 = '0; in2 = '0; op = '0;
`ifdef ALU_SIGNED_EN
    sgn = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b expected 1", in_ready);
    else passed++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", out_valid);
    else passed++;
    total++;
    if (out !== '0) $display("FAIL reset out: got %0h expected 0", out);
    else passed++;
    total++;
    if (err !== 2'b00) $display("FAIL reset err: got %b expected 00", err);
    else passed++;
  endtask

  task automatic test_add_sub();
    logic [2*WIDTH-1:0] r; logic [1:0] e; int lat;
    run_op(OP_ADD, 16'd11, 16'd51, 1'b0, r, e, lat);
    check_result("add_11_51", r, e, lat, 32'd62, 2'b00, 1);
    retire();
    total++;
    if (in_ready !== 1'b1) $display("FAIL retire in_ready: got %b expected 1", in_ready);
    else passed++;
    run_op(OP_SUB, 16'd11, 16'd51, 1'b0, r, e, lat);
    check_result("sub_11_51", r, e, lat, 32'hFFFF_FFD8, 2'b01, 1);
    retire();
    run_op(OP_ADD, 16'd62091, 16'd47411, 1'b0, r, e, lat);
    check_result("add_carry", r, e, lat, 32'd109502, 2'b01, 1);
    retire();
    run_op(OP_SUB, 16'd51, 16'd11, 1'b0, r, e, lat);
    check_result("sub_51_11", r, e, lat, 32'd40, 2'b00, 1);
    retire();
  endtask

  task automatic test_mul();
    logic [2*WIDTH-1:0] r; logic [1:0] e; int lat;
    run_op(OP_MUL, 16'd62091, 16'd47411, 1'b0, r, e, lat);
    check_result("mul_big", r, e, lat, 32'd2943796401, 2'b00, 17);
    retire();
    run_op(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, r, e, lat);
    check_result("mul_max", r, e, lat, 32'hFFFE_0001, 2'b00, 17);
    retire();
  endtask

  task automatic test_div();
    logic [2*WIDTH-1:0] r; logic [1:0] e; int lat;
    run_op(OP_DIV, 16'd62091, 16'd47411, 1'b0, r, e, lat);
    check_result("div_big", r, e, lat, 32'd1, 2'b00, 17);
    retire();
    run_op(OP_MOD, 16'd62091, 16'd47411, 1'b0, r, e, lat);
    check_result("mod_big", r, e, lat, 32'd14680, 2'b00, 17);
    retire();
    run_op(OP_DIV, 16'd1000, 16'd7, 1'b0, r, e, lat);
    check_result("div_1000_7", r, e, lat, 32'd142, 2'b00, 17);
    retire();
    run_op(OP_DIV, 16'd11, 16'd0, 1'b0, r, e, lat);
    check_result("div_zero", r, e, lat, 32'd0, 2'b10, 1);
    retire();
    run_op(OP_MOD, 16'd5, 16'd0, 1'b0, r, e, lat);
    check_result("mod_zero", r, e, lat, 32'd0, 2'b10, 1);
    retire();
  endtask

  task automatic test_illegal();
    logic [2*WIDTH-1:0] r; logic [1:0] e; int lat;
    run_op(4'b1111, 16'd3, 16'd4, 1'b0, r, e, lat);
    check_result("illegal_op", r, e, lat, 32'd0, 2'b00, 1);
    retire();
  endtask

  task automatic test_back_to_back();
    logic [2*WIDTH-1:0] r; logic [1:0] e; int lat;
    run_op(OP_MUL, 16'd300, 16'd7, 1'b0, r, e, lat);
    check_result("bp_mul", r, e, lat, 32'd2100, 2'b00, 17);
    // Offer a new command while the result is held back.
    in1 = 16'd5; in2 = 16'd6; op = OP_ADD; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (out !== 32'd2100 || err !== 2'b00 || in_ready !== 1'b0 || out_valid !== 1'b1)
        $display("FAIL hold cycle %0d: out=%0h err=%b in_ready=%b out_valid=%b expected 834 00 0 1",
                 i, out, err, in_ready, out_valid);
      else passed++;
    end
    // Retire with in_valid still high: no same-edge accept.
    retire();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL retire_no_bypass: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) $display("FAIL next_accept in_ready: got %b expected 0", in_ready);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out !== 32'd11)
      $display("FAIL next_add: out_valid=%b out=%0d expected 1 11", out_valid, out);
    else passed++;
    retire();
  endtask

  task automatic test_reset_mid_div();
    logic [2*WIDTH-1:0] r; logic [1:0] e; int lat;
    int seen_valid;
    in1 = 16'd62091; in2 = 16'd47411; op = OP_DIV; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== '0 || err !== 2'b00)
      $display("FAIL mid_div_reset: in_ready=%b out_valid=%b out=%0h err=%b expected 1 0 0 00",
               in_ready, out_valid, out, err);
    else passed++;
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen_valid++;
    end
    total++;
    if (seen_valid !== 0) $display("FAIL discarded_div: out_valid seen %0d cycles expected 0", seen_valid);
    else passed++;
    run_op(OP_ADD, 16'd11, 16'd51, 1'b0, r, e, lat);
    check_result("add_after_reset", r, e, lat, 32'd62, 2'b00, 1);
    retire();
  endtask

`ifdef ALU_SIGNED_EN
  task automatic test_signed();
    logic [2*WIDTH-1:0] r; logic [1:0] e; int lat;
    run_op(OP_DIV, 16'hFFF9, 16'd2, 1'b1, r, e, lat);
    check_result("sdiv_m7_2", r, e, lat, 32'hFFFF_FFFD, 2'b00, 17);
    retire();
    run_op(OP_MOD, 16'hFFF9, 16'd2, 1'b1, r, e, lat);
    check_result("smod_m7_2", r, e, lat, 32'hFFFF_FFFF, 2'b00, 17);
    retire();
    run_op(OP_ADD, 16'd32767, 16'd1, 1'b1, r, e, lat);
    check_result("sadd_ovf", r, e, lat, 32'h0000_8000, 2'b01, 1);
    retire();
    run_op(OP_MUL, 16'hFFFD, 16'd5, 1'b1, r, e, lat);
    check_result("smul_m3_5", r, e, lat, 32'hFFFF_FFF1, 2'b00, 17);
    retire();
    run_op(OP_DIV, 16'hFFF9, 16'd2, 1'b0, r, e, lat);
    check_result("udiv_fff9_2", r, e, lat, 32'd32764, 2'b00, 17);
    retire();
  endtask
`endif

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_illegal();
    test_back_to_back();
    test_reset_mid_div();
`ifdef ALU_SIGNED_EN
    test_signed();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
